// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: fetch vs load/store with starvation guard and 1-cycle response routing.
// Optional misalignment checking is enabled by defining MISALIGN_CHECK_EN.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } ram_size_e;
endpackage

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  ram_size_e   lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic [31:0] ram_address_o,
  output logic        ram_unsigned_o,
  output ram_size_e   ram_size_o,
  output logic [31:0] ram_data_o,
  output logic        ram_wr_enable_o,
  input  logic [31:0] ram_output_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_LSU  = 2'd2
  } resp_e;

  resp_e          resp_q, resp_d;
  logic           err_q, err_d;
  logic [CW-1:0]  starve_cnt;
  logic           grant_if, grant_lsu, misaligned;

  // Outputs are gated by rst_ni so nothing is granted while reset is held.
  always_comb begin
    grant_if  = rst_ni && if_req_i &&
                ((starve_cnt == CW'(STARVE_MAX)) || !lsu_req_i);
    grant_lsu = rst_ni && lsu_req_i && !grant_if;
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (grant_if) begin
      misaligned = (if_addr_i[1:0] != 2'b00);
    end else if (grant_lsu) begin
      case (lsu_size_i)
        HALF_WORD: misaligned = lsu_addr_i[0];
        WORD:      misaligned = (lsu_addr_i[1:0] != 2'b00);
        default:   misaligned = 1'b0;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // Misaligned accesses are granted but the RAM sees an idle drive.
  always_comb begin
    ram_address_o   = '0;
    ram_size_o      = WORD;
    ram_unsigned_o  = 1'b0;
    ram_data_o      = '0;
    ram_wr_enable_o = 1'b0;
    if (grant_if && !misaligned) begin
      ram_address_o = if_addr_i;
    end else if (grant_lsu && !misaligned) begin
      ram_address_o   = lsu_addr_i;
      ram_size_o      = lsu_size_i;
      ram_unsigned_o  = lsu_unsigned_i;
      ram_data_o      = lsu_wdata_i;
      ram_wr_enable_o = lsu_we_i;
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    err_d  = misaligned;
    if (grant_if) begin
      resp_d = RESP_IF;
    end else if (grant_lsu && (!lsu_we_i || misaligned)) begin
      resp_d = RESP_LSU;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q     <= RESP_NONE;
      err_q      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      resp_q <= resp_d;
      err_q  <= err_d;
      if (!if_req_i || grant_if) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    if_gnt_o     = grant_if;
    lsu_gnt_o    = grant_lsu;
    if_rvalid_o  = rst_ni && (resp_q == RESP_IF);
    lsu_rvalid_o = rst_ni && (resp_q == RESP_LSU);
    if_err_o     = if_rvalid_o && err_q;
    lsu_err_o    = lsu_rvalid_o && err_q;
    if_rdata_o   = (if_rvalid_o && !err_q) ? ram_output_i : '0;
    lsu_rdata_o  = (lsu_rvalid_o && !err_q) ? ram_output_i : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM model, byte-level shadow memory scoreboard, directed vectors.
// Expectations follow MISALIGN_CHECK_EN when it is defined for the build.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_uns = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  ram_size_e   lsu_size = WORD;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic [31:0] ram_address, ram_data;
  logic        ram_unsigned, ram_we;
  ram_size_e   ram_size;
  logic [31:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
    .lsu_size_i(lsu_size), .lsu_unsigned_i(lsu_uns), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .lsu_err_o(lsu_err),
    .ram_address_o(ram_address), .ram_unsigned_o(ram_unsigned),
    .ram_size_o(ram_size), .ram_data_o(ram_data),
    .ram_wr_enable_o(ram_we), .ram_output_i(ram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RAM model: word array with byte lanes, registered read with sign/zero extension.
  logic [31:0] ram_mem [64];

  function automatic logic [31:0] ram_read(input logic [31:0] a, input ram_size_e s, input logic u);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ram_mem[a[7:2]];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (s)
      BYTE:      return u ? {24'h0, b} : {{24{b[7]}}, b};
      HALF_WORD: return u ? {16'h0, h} : {{16{h[15]}}, h};
      default:   return w;
    endcase
  endfunction

  always @(posedge clk) begin
    ram_rdata <= ram_read(ram_address, ram_size, ram_unsigned);
    if (ram_we) begin
      case (ram_size)
        BYTE:      ram_mem[ram_address[7:2]][8*ram_address[1:0] +: 8] <= ram_data[7:0];
        HALF_WORD: ram_mem[ram_address[7:2]][16*ram_address[1] +: 16] <= ram_data[15:0];
        default:   ram_mem[ram_address[7:2]] <= ram_data;
      endcase
    end
  end

  // Scoreboard memory: flat little-endian byte array.
  logic [7:0] shadow [256];

  function automatic logic [31:0] sh_read(input logic [31:0] addr, input ram_size_e s, input logic u);
    int a;
    logic [15:0] h;
    a = int'(addr[7:0]);
    case (s)
      BYTE: return u ? {24'h0, shadow[a]} : {{24{shadow[a][7]}}, shadow[a]};
      HALF_WORD: begin
        a = a - (a % 2);
        h = {shadow[a+1], shadow[a]};
        return u ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        a = a - (a % 4);
        return {shadow[a+3], shadow[a+2], shadow[a+1], shadow[a]};
      end
    endcase
  endfunction

  task automatic sh_write(input logic [31:0] addr, input ram_size_e s, input logic [31:0] d);
    int a;
    int n;
    a = int'(addr[7:0]);
    n = (s == BYTE) ? 1 : (s == HALF_WORD) ? 2 : 4;
    a = a - (a % n);
    for (int k = 0; k < n; k++) shadow[a+k] = d[8*k +: 8];
  endtask

  function automatic bit is_mis(input bit fetch, input logic [31:0] a, input ram_size_e s);
    if (fetch) return MIS_EN && (a[1:0] != 2'b00);
    case (s)
      HALF_WORD: return MIS_EN && a[0];
      WORD:      return MIS_EN && (a[1:0] != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

  // Behavioural model: owner of the pending response, its data, and denied-fetch streak.
  int          owner = 0;   // 0 none, 1 fetch, 2 lsu
  logic [31:0] pend_data = '0;
  bit          pend_err = 1'b0;
  int          starve = 0;

  always @(negedge clk) begin
    bit gi, gl, mis;
    logic [31:0] e_addr, e_data;
    logic [1:0]  e_size;
    bit          e_uns, e_we;
    if (!rst_n) begin
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_lsu_gnt", 32'(lsu_gnt), 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_lsu_rvalid", 32'(lsu_rvalid), 0);
      chk("rst_errs", {30'h0, if_err, lsu_err}, 0);
      chk("rst_rdata", if_rdata | lsu_rdata, 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", ram_address, 0);
      chk("rst_ram_size", 32'(ram_size), 32'(WORD));
      owner = 0;
      starve = 0;
    end else begin
      chk("if_rvalid", 32'(if_rvalid), 32'(owner == 1));
      chk("lsu_rvalid", 32'(lsu_rvalid), 32'(owner == 2));
      chk("if_rdata", if_rdata, (owner == 1) ? pend_data : 32'h0);
      chk("lsu_rdata", lsu_rdata, (owner == 2) ? pend_data : 32'h0);
      chk("if_err", 32'(if_err), 32'(owner == 1 && pend_err));
      chk("lsu_err", 32'(lsu_err), 32'(owner == 2 && pend_err));

      gi  = if_req && (starve >= STARVE_MAX || !lsu_req);
      gl  = lsu_req && !gi;
      mis = gi ? is_mis(1'b1, if_addr, WORD) : gl ? is_mis(1'b0, lsu_addr, lsu_size) : 1'b0;
      e_addr = '0; e_data = '0; e_size = 2'(WORD); e_uns = 1'b0; e_we = 1'b0;
      if (gi && !mis) e_addr = if_addr;
      if (gl && !mis) begin
        e_addr = lsu_addr; e_data = lsu_wdata; e_size = 2'(lsu_size);
        e_uns = lsu_uns; e_we = lsu_we;
      end
      chk("if_gnt", 32'(if_gnt), 32'(gi));
      chk("lsu_gnt", 32'(lsu_gnt), 32'(gl));
      chk("ram_addr", ram_address, e_addr);
      chk("ram_data", ram_data, e_data);
      chk("ram_size", 32'(ram_size), 32'(e_size));
      chk("ram_uns", 32'(ram_unsigned), 32'(e_uns));
      chk("ram_we", 32'(ram_we), 32'(e_we));

      if (gl && lsu_we && !mis) sh_write(lsu_addr, lsu_size, lsu_wdata);
      pend_err = mis;
      if (gi) begin
        owner = 1;
        pend_data = mis ? 32'h0 : sh_read(if_addr, WORD, 1'b0);
      end else if (gl && (!lsu_we || mis)) begin
        owner = 2;
        pend_data = mis ? 32'h0 : sh_read(lsu_addr, lsu_size, lsu_uns);
      end else begin
        owner = 0;
      end
      if (!if_req || gi) starve = 0;
      else if (starve < STARVE_MAX) starve = starve + 1;
    end
  end

  task automatic drive(input bit ir, input logic [31:0] ia, input bit lr, input bit we,
                       input logic [31:0] la, input ram_size_e sz, input bit un,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia;
    lsu_req = lr; lsu_we = we; lsu_addr = la; lsu_size = sz; lsu_uns = un; lsu_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, WORD, 1'b0, 32'h0);
  endtask

  logic [9:0] pattern;
  logic [4:0] pattern2;

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i == 4) ? 32'hDEADBEEF : {8'(i), 8'(i + 17), 8'hC3, 8'(i * 7)};
      ram_mem[i] = w;
      for (int k = 0; k < 4; k++) shadow[4*i+k] = w[8*k +: 8];
    end
    repeat (2) @(negedge clk);

    // Fetch only, in the first cycle out of reset
    @(posedge clk); #1;
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("lit_fetch_gnt", 32'(if_gnt), 1);
    chk("lit_fetch_lsu_gnt", 32'(lsu_gnt), 0);
    idle();
    @(negedge clk);
    chk("lit_fetch_rvalid", 32'(if_rvalid), 1);
    chk("lit_fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("lit_fetch_lsu_idle", 32'(lsu_rvalid), 0);

    // Store then load, byte sign/zero extension
    drive(1'b0, 0, 1'b1, 1'b1, 32'h20, WORD, 1'b0, 32'h12345678);
    @(negedge clk);
    chk("lit_store_we", 32'(ram_we), 1);
    drive(1'b0, 0, 1'b1, 1'b0, 32'h20, WORD, 1'b0, 32'h0);
    @(negedge clk);
    chk("lit_store_no_rvalid", 32'(lsu_rvalid), 0);
    drive(1'b0, 0, 1'b1, 1'b1, 32'h20, BYTE, 1'b0, 32'h00000080);
    @(negedge clk);
    chk("lit_load_word", lsu_rdata, 32'h12345678);
    drive(1'b0, 0, 1'b1, 1'b0, 32'h20, BYTE, 1'b0, 32'h0);
    drive(1'b0, 0, 1'b1, 1'b0, 32'h20, BYTE, 1'b1, 32'h0);
    @(negedge clk);
    chk("lit_load_signed_byte", lsu_rdata, 32'hFFFFFF80);
    idle();
    @(negedge clk);
    chk("lit_load_unsigned_byte", lsu_rdata, 32'h00000080);

    // Back-to-back alternation
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b1, 32'h40 + 32'(4*i), 1'b0, 1'b0, 0, WORD, 1'b0, 0);
      else drive(1'b0, 0, 1'b1, 1'b0, 32'h80 + 32'(4*i), HALF_WORD, 1'b0, 0);
    end
    idle();

    // Contention: both requesting continuously
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h44, WORD, 1'b0, 0);
      @(negedge clk);
      pattern[i] = if_gnt;
    end
    chk("lit_contention_pattern", 32'(pattern), 32'(10'b1000010000));
    idle();

    // Misaligned word store at 0x22
    drive(1'b0, 0, 1'b1, 1'b1, 32'h22, WORD, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    chk("lit_mis_gnt", 32'(lsu_gnt), 1);
    chk("lit_mis_we", 32'(ram_we), 32'(!MIS_EN));
    drive(1'b0, 0, 1'b1, 1'b0, 32'h20, WORD, 1'b0, 0);
    @(negedge clk);
    chk("lit_mis_rvalid", 32'(lsu_rvalid), 32'(MIS_EN));
    chk("lit_mis_err", 32'(lsu_err), 32'(MIS_EN));
    idle();
    @(negedge clk);
    chk("lit_mis_word20", lsu_rdata, MIS_EN ? 32'h12345680 : 32'hCAFEF00D);

    // Reset asserted between a load grant and its response
    drive(1'b0, 0, 1'b1, 1'b0, 32'h20, WORD, 1'b0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    lsu_req = 1'b0;
    @(negedge clk);
    chk("lit_rst_drop_rvalid", 32'(lsu_rvalid), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h34, 1'b1, 1'b0, 32'h48, WORD, 1'b0, 0);
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
      if (i == 0) chk("lit_rst_no_late_rvalid", 32'(lsu_rvalid), 0);
      pattern2[i] = if_gnt;
    end
    chk("lit_rst_starve_restart", 32'(pattern2), 32'(5'b10000));
    idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
